// File: rtl/dma_pkg.sv
// Shared widths, FSM state encoding and range check for the DMA copy sequencer.
package dma_pkg;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 8;
  localparam int MEM_DEPTH = 192;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    READ,
    WAIT,
    WRITE,
    DONE
  } dma_state_e;

  // One extra bit so base+cnt cannot wrap before the compare against the memory depth.
  function automatic logic range_bad(input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] cnt);
    logic [ADDR_W:0] end_v;
    end_v = {1'b0, base} + {1'b0, cnt};
    return end_v > (ADDR_W+1)'(MEM_DEPTH);
  endfunction
endpackage

// File: rtl/dma_copy_ctrl.sv
// Single-channel DMA word copier owning the shared memory port; all outputs registered.
// Optional block fill is enabled with the DMA_FILL_EN macro.
//
// state | meaning
// IDLE  | waiting for start; err/words_done hold last result
// CHECK | zero-length and range check of latched config
// READ  | source address presented, mem_wr=0
// WAIT  | read data arrives, captured at end of cycle
// WRITE | destination write; pointers and count advance
// DONE  | one-cycle done pulse, busy low
module dma_copy_ctrl
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              abort,
`ifdef DMA_FILL_EN
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_value,
`endif
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] words_done,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              fill_req;
  logic [DATA_W-1:0] fill_val;

`ifdef DMA_FILL_EN
  assign fill_req = fill_mode;
  assign fill_val = fill_value;
`else
  assign fill_req = 1'b0;
  assign fill_val = '0;
`endif

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              fill_q, fill_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cfg_bad;

  // Fill never reads, so only the destination range matters there.
  assign cfg_bad = range_bad(dst_q, len_q) || (!fill_q && range_bad(src_q, len_q));

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    fill_d     = fill_q;
    fill_val_d = fill_val_q;
    words_d    = words_q;
    err_d      = err_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d      = src_addr;
          dst_d      = dst_addr;
          len_d      = len;
          fill_d     = fill_req;
          fill_val_d = fill_val;
          words_d    = '0;
          err_d      = 1'b0;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (len_q == '0) begin
          state_d = DONE;
        end else if (cfg_bad) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = fill_q ? WRITE : READ;
        end
      end
      READ: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wdata_d = mem_rdata;
          state_d = WRITE;
        end
      end
      WRITE: begin
        src_d   = src_q + 1'b1;
        dst_d   = dst_q + 1'b1;
        words_d = words_q + 1'b1;
        if (abort) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (words_d == len_q) begin
          state_d = DONE;
        end else begin
          state_d = fill_q ? WRITE : READ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == CHECK) || (state_d == READ) ||
             (state_d == WAIT)  || (state_d == WRITE);
    done_d = (state_d == DONE);
    wr_d   = (state_d == WRITE);

    addr_d = addr_q;
    if (state_d == READ) begin
      addr_d = src_d;
    end else if (state_d == WRITE) begin
      addr_d = dst_d;
    end

    if (state_d == WRITE && fill_q) begin
      wdata_d = fill_val_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      fill_q     <= 1'b0;
      fill_val_q <= '0;
      words_q    <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      fill_q     <= fill_d;
      fill_val_q <= fill_val_d;
      words_q    <= words_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign words_done = words_q;
  assign mem_wr     = wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Scoreboard bench for dma_copy_ctrl with a synchronous-read memory model.
module tb_dma_copy_ctrl;
  import dma_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] len;
  logic              abort;
  logic              fill_mode;
  logic [DATA_W-1:0] fill_value;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] words_done;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  dma_copy_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .abort      (abort),
`ifdef DMA_FILL_EN
    .fill_mode  (fill_mode),
    .fill_value (fill_value),
`endif
    .busy       (busy),
    .done       (done),
    .err        (err),
    .words_done (words_done),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  logic [DATA_W-1:0] mem [0:255];
  logic              init_req;

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + DATA_W'(i);
      mem[1] <= 32'd8;
      mem[2] <= 32'd9;
      mem[3] <= 32'd12;
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  total = 0;
  int  bad = 0;
  int  wr_cnt, wr_first, wr_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_wr(input int a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = ADDR_W'(a);
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic push_copy(input int s, input int d, input int n);
    for (int i = 0; i < n; i++) push_wr(d + i, mem[s + i]);
  endtask

  // Cycle 1 is the first cycle after the edge that samples start.
  task automatic run_xfer(input string tag, input int s, input int d, input int n,
                          input logic fm, input logic [DATA_W-1:0] fv,
                          input int abort_cyc, input int restart_cyc,
                          input int exp_cyc, input logic exp_err, input int exp_words);
    int   cyc;
    logic got;
    wr_t  e;
    @(negedge clk);
    start      = 1'b1;
    src_addr   = ADDR_W'(s);
    dst_addr   = ADDR_W'(d);
    len        = ADDR_W'(n);
    fill_mode  = fm;
    fill_value = fv;
    @(posedge clk);
    #1;
    start     = 1'b0;
    fill_mode = 1'b0;
    cyc = 0; got = 1'b0; wr_cnt = 0; wr_first = 0; wr_last = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      abort = (cyc == abort_cyc);
      if (cyc == restart_cyc) begin
        start = 1'b1; src_addr = 8'd0; dst_addr = 8'd50; len = 8'd2;
      end else begin
        start = 1'b0;
      end
      if (mem_wr) begin
        wr_cnt++;
        if (wr_cnt == 1) wr_first = cyc;
        wr_last = cyc;
        if (sb_q.size() == 0) begin
          chk({tag, "_wr_unexpected"}, 32'(mem_wr), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk({tag, "_wr_addr"}, 32'(mem_addr), 32'(e.addr));
          chk({tag, "_wr_data"}, mem_wdata, e.data);
        end
      end
      if (done) got = 1'b1;
    end
    abort = 1'b0;
    start = 1'b0;
    if (!got) begin
      chk({tag, "_done_seen"}, 32'(done), 32'd1);
    end else begin
      chk({tag, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_err"}, 32'(err), 32'(exp_err));
      chk({tag, "_words"}, 32'(words_done), 32'(exp_words));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_err_hold"}, 32'(err), 32'(exp_err));
      chk({tag, "_words_hold"}, 32'(words_done), 32'(exp_words));
    end
    chk({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst_n = 1'b0; init_req = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; fill_mode = 1'b0; fill_value = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr", 32'(mem_wr), 32'd0);
    chk("rst_words", 32'(words_done), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1; init_req = 1'b0;
    @(negedge clk);

    push_copy(1, 100, 3);
    run_xfer("copy", 1, 100, 3, 1'b0, '0, 0, 0, 11, 1'b0, 3);
    chk("copy_mem100", mem[100], 32'd8);
    chk("copy_mem101", mem[101], 32'd9);
    chk("copy_mem102", mem[102], 32'd12);

    run_xfer("zero", 0, 0, 0, 1'b0, '0, 0, 0, 2, 1'b0, 0);
    run_xfer("src_range", 190, 0, 3, 1'b0, '0, 0, 0, 2, 1'b1, 0);
    run_xfer("dst_range", 0, 190, 3, 1'b0, '0, 0, 0, 2, 1'b1, 0);

    push_copy(20, 120, 1);
    run_xfer("abort", 20, 120, 5, 1'b0, '0, 6, 0, 7, 1'b1, 1);
    chk("abort_mem120", mem[120], 32'h1000_0014);
    chk("abort_mem121", mem[121], 32'h1000_0079);

    push_copy(5, 191, 1);
    run_xfer("bound", 5, 191, 1, 1'b0, '0, 0, 2, 5, 1'b0, 1);
    chk("bound_mem191", mem[191], 32'h1000_0005);
    chk("bound_mem50", mem[50], 32'h1000_0032);

    @(negedge clk);
    start = 1'b1; src_addr = 8'd30; dst_addr = 8'd130; len = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_pre_wr", 32'(mem_wr), 32'd1);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      chk("rst_mid_wr", 32'(mem_wr), 32'd0);
      chk("rst_mid_words", 32'(words_done), 32'd0);
      chk("rst_mid_addr", 32'(mem_addr), 32'd0);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || mem_wr || busy) seen = 1'b1;
    end
    chk("rst_mid_quiet", 32'(seen), 32'd0);

`ifdef DMA_FILL_EN
    for (int i = 0; i < 4; i++) push_wr(10 + i, 32'hA5A5_A5A5);
    run_xfer("fill", 250, 10, 4, 1'b1, 32'hA5A5_A5A5, 0, 0, 6, 1'b0, 4);
    chk("fill_wr_cnt", 32'(wr_cnt), 32'd4);
    chk("fill_wr_first", 32'(wr_first), 32'd2);
    chk("fill_wr_span", 32'(wr_last - wr_first), 32'd3);
    for (int i = 10; i < 14; i++) chk("fill_mem", mem[i], 32'hA5A5_A5A5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
